// File: rtl/read_req_tag_arbiter.sv
// read_req_tag_arbiter
//   Round-robin arbiter on the read-request path. It picks one of N = 3*C_NUM_CHNL
//   requesters (main, SG RX and SG TX for each channel), encodes the winner as a
//   6-bit internal tag {type, chnl}, trades that tag for an external PCIe tag from
//   the reorder queue, and then issues the request to the TX engine.
//   Build option: define ARB_SG_PRIORITY_EN to give SG requesters (types 1 and 2)
//   strict priority over main requesters. The rotation pointer is still used
//   within the favoured group.
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   REQ[N]            level request, index = type*C_NUM_CHNL + chnl
//   REQ_ADDR, REQ_LEN per-requester address and length slices
//   REQ_ACK[N]        one-cycle pulse when that request has been issued
//   INT_TAG(_VALID)   internal tag offered for exchange
//   EXT_TAG(_VALID)   external tag returned by the reorder queue
//   TX_REQ_*          valid/ready request to the TX engine with addr/len/tag
module read_req_tag_arbiter #(
    parameter int C_NUM_CHNL   = 12,
    parameter int C_TAG_WIDTH  = 5,
    parameter int C_ADDR_WIDTH = 64,
    parameter int C_LEN_WIDTH  = 10
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [3*C_NUM_CHNL-1:0]             REQ,
    input  logic [3*C_NUM_CHNL*C_ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [3*C_NUM_CHNL*C_LEN_WIDTH-1:0] REQ_LEN,
    output logic [3*C_NUM_CHNL-1:0]             REQ_ACK,
    output logic [5:0]                          INT_TAG,
    output logic                                INT_TAG_VALID,
    input  logic [C_TAG_WIDTH-1:0]              EXT_TAG,
    input  logic                                EXT_TAG_VALID,
    output logic                                TX_REQ_VALID,
    input  logic                                TX_REQ_READY,
    output logic [C_ADDR_WIDTH-1:0]             TX_REQ_ADDR,
    output logic [C_LEN_WIDTH-1:0]              TX_REQ_LEN,
    output logic [C_TAG_WIDTH-1:0]              TX_REQ_TAG
);

    localparam int N  = 3 * C_NUM_CHNL;
    localparam int GW = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_TAG, S_ISSUE} state_t;

    state_t            state, state_nxt;
    logic [GW-1:0]     rptr;
    logic [GW-1:0]     gnt;
    logic [N-1:0]      eligible;
    logic [N-1:0]      cand;
    logic              found;
    logic [GW-1:0]     win;
    logic [GW-1:0]     idx_w;
    int                idx;
    int                win_type;
    int                win_chnl;
    logic [5:0]        win_tag;
    logic [GW-1:0]     rptr_nxt;
    logic [C_ADDR_WIDTH-1:0] sel_addr;
    logic [C_LEN_WIDTH-1:0]  sel_len;

    // Arbitration. The registered ack is masked out so that a requester
    // that is acknowledged this cycle cannot be granted again before it
    // has had a chance to drop REQ.
    always_comb begin
        eligible = REQ & ~REQ_ACK;
`ifdef ARB_SG_PRIORITY_EN
        if (|eligible[N-1:C_NUM_CHNL])
            cand = {eligible[N-1:C_NUM_CHNL], {C_NUM_CHNL{1'b0}}};
        else
            cand = eligible;
`else
        cand = eligible;
`endif
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idx_w = '0;
        // Walk cyclically from rptr and take the first candidate found.
        for (int k = 0; k < N; k++) begin
            idx = int'(rptr) + k;
            if (idx >= N) idx = idx - N;
            idx_w = GW'(idx);
            if (!found && cand[idx_w]) begin
                found = 1'b1;
                win   = idx_w;
            end
        end
        win_type = int'(win) / C_NUM_CHNL;
        win_chnl = int'(win) % C_NUM_CHNL;
        win_tag  = {win_type[1:0], win_chnl[3:0]};
        rptr_nxt = (int'(win) == N - 1) ? '0 : GW'(int'(win) + 1);
        sel_addr = REQ_ADDR[int'(win)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
        sel_len  = REQ_LEN[int'(win)*C_LEN_WIDTH +: C_LEN_WIDTH];
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (found)         state_nxt = S_TAG;
            S_TAG:   if (EXT_TAG_VALID) state_nxt = S_ISSUE;
            S_ISSUE: if (TX_REQ_READY)  state_nxt = S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs follow the state directly
    always_comb begin
        INT_TAG_VALID = (state == S_TAG);
        TX_REQ_VALID  = (state == S_ISSUE);
    end

    // Grant datapath. Addr and len are latched at grant time, so a requester
    // that drops REQ mid-flight does not disturb the transfer in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rptr        <= '0;
            gnt         <= '0;
            REQ_ACK     <= '0;
            INT_TAG     <= '0;
            TX_REQ_ADDR <= '0;
            TX_REQ_LEN  <= '0;
            TX_REQ_TAG  <= '0;
        end else begin
            REQ_ACK <= '0;
            case (state)
                S_IDLE: if (found) begin
                    gnt         <= win;
                    rptr        <= rptr_nxt;
                    INT_TAG     <= win_tag;
                    TX_REQ_ADDR <= sel_addr;
                    TX_REQ_LEN  <= sel_len;
                end
                S_TAG: if (EXT_TAG_VALID) TX_REQ_TAG <= EXT_TAG;
                S_ISSUE: if (TX_REQ_READY) REQ_ACK[gnt] <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
